// File: rtl/rr_grant_burst_ctrl.sv
// rr_grant_burst_ctrl: takes the one-hot grant from the round-robin arbiter,
// runs a valid/ready burst for the granted client while stalling the arbiter,
// flags malformed (multi-hot) grants, and watches every client for starvation.
module rr_grant_burst_ctrl #(
  parameter int CLIENTS  = 32,
  parameter int IDX_W    = $clog2(CLIENTS),
  parameter int BEAT_W   = 4,
  parameter int MAX_WAIT = 31
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CLIENTS-1:0]        request,
  input  logic [CLIENTS-1:0]        grant,
  input  logic [CLIENTS*BEAT_W-1:0] burst_len,
  output logic                      stall,
  output logic                      owner_valid,
  output logic [IDX_W-1:0]          owner_idx,
  output logic                      beat_valid,
  output logic                      beat_last,
  input  logic                      beat_ready,
  output logic                      grant_err,
  output logic [CLIENTS-1:0]        starve_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      owner_idx_q, owner_idx_d;
  logic [BEAT_W:0]       beats_left_q, beats_left_d;
  logic                  grant_err_q, grant_err_d;
  logic [CLIENTS-1:0]    starve_err_q, starve_err_d;
  logic [CNT_W-1:0]      wait_q [CLIENTS];
  logic [CNT_W-1:0]      wait_d [CLIENTS];

  logic                  grant_any;
  logic                  grant_multi;
  logic [IDX_W-1:0]      grant_idx;
  logic [BEAT_W-1:0]     grant_len;

  // Outputs are pure decodes of the state and the remaining-beat count.
  assign stall       = (state_q == BURST);
  assign owner_valid = (state_q == BURST);
  assign beat_valid  = (state_q == BURST);
  assign beat_last   = (state_q == BURST) && (beats_left_q == (BEAT_W+1)'(1));
  assign owner_idx   = owner_idx_q;
  assign grant_err   = grant_err_q;
  assign starve_err  = starve_err_q;

  // Classify the grant vector and encode the granted client with its burst length.
  always_comb begin
    grant_any   = |grant;
    grant_multi = (grant & (grant - CLIENTS'(1))) != '0;
    grant_idx   = '0;
    grant_len   = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        grant_len = burst_len[i*BEAT_W +: BEAT_W];
      end
    end
  end

  // Next-state logic: ownership capture in IDLE, beat countdown in BURST, sticky grant error.
  always_comb begin
    state_d      = state_q;
    owner_idx_d  = owner_idx_q;
    beats_left_d = beats_left_q;
    grant_err_d  = grant_err_q | (grant_any && grant_multi);
    case (state_q)
      IDLE: begin
        if (grant_any && !grant_multi) begin
          state_d      = BURST;
          owner_idx_d  = grant_idx;
          // A zero length still moves one beat.
          beats_left_d = (grant_len == '0) ? (BEAT_W+1)'(1) : {1'b0, grant_len};
        end
      end
      BURST: begin
        if (beat_ready) begin
          beats_left_d = beats_left_q - (BEAT_W+1)'(1);
          if (beats_left_q == (BEAT_W+1)'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-client starvation watchdog: saturating wait counters and sticky error flags.
  always_comb begin
    starve_err_d = starve_err_q;
    for (int i = 0; i < CLIENTS; i++) begin
      wait_d[i] = '0;
      if (request[i] && !grant[i]) begin
        if (wait_q[i] == CNT_W'(MAX_WAIT)) begin
          wait_d[i]       = wait_q[i];
          starve_err_d[i] = 1'b1;
        end else begin
          wait_d[i] = wait_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset abandons any burst in flight and clears all error state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_idx_q  <= '0;
      beats_left_q <= '0;
      grant_err_q  <= 1'b0;
      starve_err_q <= '0;
      for (int i = 0; i < CLIENTS; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      owner_idx_q  <= owner_idx_d;
      beats_left_q <= beats_left_d;
      grant_err_q  <= grant_err_d;
      starve_err_q <= starve_err_d;
      for (int i = 0; i < CLIENTS; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rr_grant_burst_ctrl.sv
// Directed testbench for rr_grant_burst_ctrl with hand-computed expectations.
module tb_rr_grant_burst_ctrl;

  localparam int CLIENTS = 32;
  localparam int IDX_W   = 5;
  localparam int BEAT_W  = 4;

  logic                      clock;
  logic                      reset;
  logic [CLIENTS-1:0]        request;
  logic [CLIENTS-1:0]        grant;
  logic [CLIENTS*BEAT_W-1:0] burst_len;
  logic                      stall;
  logic                      owner_valid;
  logic [IDX_W-1:0]          owner_idx;
  logic                      beat_valid;
  logic                      beat_last;
  logic                      beat_ready;
  logic                      grant_err;
  logic [CLIENTS-1:0]        starve_err;

  int checks = 0;
  int errors = 0;

  rr_grant_burst_ctrl #(
    .CLIENTS (CLIENTS),
    .IDX_W   (IDX_W),
    .BEAT_W  (BEAT_W),
    .MAX_WAIT(31)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .request    (request),
    .grant      (grant),
    .burst_len  (burst_len),
    .stall      (stall),
    .owner_valid(owner_valid),
    .owner_idx  (owner_idx),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .beat_ready (beat_ready),
    .grant_err  (grant_err),
    .starve_err (starve_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Set a client's length and present a one-cycle grant.
  task automatic start(input int client, input logic [BEAT_W-1:0] len);
    burst_len[client*BEAT_W +: BEAT_W] = len;
    grant = 32'd1 << client;
    step();
    grant = '0;
  endtask

  // Run the active burst to completion, counting handshakes and where beat_last appeared.
  task automatic drain(output int hs, output int lpos, output int lcnt);
    hs = 0; lpos = 0; lcnt = 0;
    for (int c = 0; c < 64; c++) begin
      if (!stall) break;
      if (beat_valid && beat_ready) begin
        hs++;
        if (beat_last) begin
          lcnt++;
          lpos = hs;
        end
      end
      step();
    end
    check_eq("drain_stall_low", {31'd0, stall}, 32'd0);
  endtask

  int hs, lpos, lcnt;

  initial begin
    reset = 1'b1; request = '0; grant = '0; burst_len = '0; beat_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    check_eq("rst_stall",      {31'd0, stall},       32'd0);
    check_eq("rst_owner_vld",  {31'd0, owner_valid}, 32'd0);
    check_eq("rst_beat_vld",   {31'd0, beat_valid},  32'd0);
    check_eq("rst_beat_last",  {31'd0, beat_last},   32'd0);
    check_eq("rst_owner_idx",  {27'd0, owner_idx},   32'd0);
    check_eq("rst_grant_err",  {31'd0, grant_err},   32'd0);
    check_eq("rst_starve_err", starve_err,           32'd0);

    // Single burst: client 5, length 3, always ready
    beat_ready = 1'b1;
    start(5, 4'd3);
    check_eq("sb_t1_stall", {31'd0, stall},     32'd1);
    check_eq("sb_t1_owner", {27'd0, owner_idx}, 32'd5);
    check_eq("sb_t1_last",  {31'd0, beat_last}, 32'd0);
    step();
    check_eq("sb_t2_stall", {31'd0, stall},     32'd1);
    check_eq("sb_t2_last",  {31'd0, beat_last}, 32'd0);
    step();
    check_eq("sb_t3_stall", {31'd0, stall},     32'd1);
    check_eq("sb_t3_owner", {27'd0, owner_idx}, 32'd5);
    check_eq("sb_t3_last",  {31'd0, beat_last}, 32'd1);
    step();
    check_eq("sb_t4_stall", {31'd0, stall},     32'd0);
    check_eq("sb_t4_bvld",  {31'd0, beat_valid}, 32'd0);

    // Back-to-back: grant in the first idle cycle starts a new burst immediately
    start(6, 4'd1);
    check_eq("b2b_stall", {31'd0, stall},     32'd1);
    check_eq("b2b_owner", {27'd0, owner_idx}, 32'd6);
    drain(hs, lpos, lcnt);
    check_eq("b2b_hs", hs, 32'd1);

    // Backpressure: length 2, ready low for 4 cycles
    beat_ready = 1'b0;
    start(2, 4'd2);
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_bvld",  {31'd0, beat_valid}, 32'd1);
      check_eq("bp_owner", {27'd0, owner_idx},  32'd2);
      check_eq("bp_last",  {31'd0, beat_last},  32'd0);
      step();
    end
    beat_ready = 1'b1;
    drain(hs, lpos, lcnt);
    check_eq("bp_hs",   hs,   32'd2);
    check_eq("bp_lpos", lpos, 32'd2);
    check_eq("bp_lcnt", lcnt, 32'd1);

    // Zero length behaves as one beat
    start(7, 4'd0);
    check_eq("zl_last", {31'd0, beat_last}, 32'd1);
    drain(hs, lpos, lcnt);
    check_eq("zl_hs",   hs,   32'd1);
    check_eq("zl_lpos", lpos, 32'd1);

    // Maximum length: 15 beats, last only on the 15th
    start(9, 4'd15);
    check_eq("ml_owner", {27'd0, owner_idx}, 32'd9);
    drain(hs, lpos, lcnt);
    check_eq("ml_hs",   hs,   32'd15);
    check_eq("ml_lpos", lpos, 32'd15);
    check_eq("ml_lcnt", lcnt, 32'd1);

    // Illegal multi-hot grant in IDLE
    grant = 32'h0000_0011;
    step();
    grant = '0;
    check_eq("ig_stall",     {31'd0, stall},       32'd0);
    check_eq("ig_owner_vld", {31'd0, owner_valid}, 32'd0);
    check_eq("ig_err",       {31'd0, grant_err},   32'd1);
    step(); step(); step();
    check_eq("ig_err_sticky", {31'd0, grant_err}, 32'd1);
    check_eq("ig_still_idle", {31'd0, stall},     32'd0);

    // Watchdog: grant at offset 31 is in time
    request = 32'd1 << 4;
    for (int k = 0; k < 31; k++) step();
    grant = 32'd1 << 4;
    step();
    check_eq("wd_ok_err", starve_err, 32'd0);
    grant = '0; request = '0;
    step(); step();
    check_eq("wd_ok_err2", starve_err, 32'd0);

    // Watchdog: no grant through offset 31 flags at offset 32
    request = 32'd1 << 4;
    for (int k = 0; k < 31; k++) step();
    check_eq("wd_pre_err", starve_err, 32'd0);
    step();
    check_eq("wd_err", starve_err, 32'd1 << 4);
    request = '0;
    step();
    check_eq("wd_err_sticky", starve_err, 32'd1 << 4);

    // Multi-hot during BURST flags an error without changing ownership, then reset mid-burst
    start(3, 4'd5);
    grant = 32'h0000_0011;
    step();
    grant = '0;
    check_eq("mb_err",   {31'd0, grant_err}, 32'd1);
    check_eq("mb_owner", {27'd0, owner_idx}, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mr_stall",  {31'd0, stall},      32'd0);
    check_eq("mr_bvld",   {31'd0, beat_valid}, 32'd0);
    check_eq("mr_gerr",   {31'd0, grant_err},  32'd0);
    check_eq("mr_serr",   starve_err,          32'd0);
    check_eq("mr_owner",  {27'd0, owner_idx},  32'd0);
    step();
    check_eq("mr_idle", {31'd0, stall}, 32'd0);
    start(3, 4'd5);
    check_eq("mr_new_owner", {27'd0, owner_idx}, 32'd3);
    drain(hs, lpos, lcnt);
    check_eq("mr_new_hs",   hs,   32'd5);
    check_eq("mr_new_lpos", lpos, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
